// File: rtl/four_bit_serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Holds the FSM state encoding and the default operand width.
package four_bit_serial_subtractor_pkg;

  localparam int WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/four_bit_serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell: Diff = X - Y - Bin.
// Ports: X, Y, Bin in; Diff, Bout out (Bout=1 when X < Y + Bin).
module full_subtractor (
  input  logic X,
  input  logic Y,
  input  logic Bin,
  output logic Diff,
  output logic Bout
);

  assign Diff = X ^ Y ^ Bin;
  assign Bout = (~X & Y) | (~(X ^ Y) & Bin);

endmodule

// File: rtl/four_bit_serial_subtractor.sv
// Bit-serial subtractor: one bit per clock, LSB first.
// Ports: clk, rst, start, A, B, Bin in; D, Bout, V, Z, busy, done out.
module four_bit_serial_subtractor
  import four_bit_serial_subtractor_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             V,
  output logic             Z,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             brw_q, brw_d;
  logic             bout_q, bout_d;
  logic             v_q, v_d;
  logic             z_q, z_d;

  logic             fs_diff;
  logic             fs_bout;
  logic             last;
  logic [WIDTH-1:0] shifted;

  full_subtractor u_fs (
    .X    (a_q[cnt_q]),
    .Y    (b_q[cnt_q]),
    .Bin  (brw_q),
    .Diff (fs_diff),
    .Bout (fs_bout)
  );

  assign last = (cnt_q == CW'(WIDTH - 1));

  // Result fills from the top so bit 0 lands in place after WIDTH steps.
  assign shifted = {fs_diff, res_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    brw_d   = brw_q;
    d_d     = d_q;
    bout_d  = bout_q;
    v_d     = v_q;
    z_d     = z_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          brw_d   = Bin;
          cnt_d   = '0;
          res_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        res_d = shifted;
        brw_d = fs_bout;
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          state_d = DONE;
          d_d     = shifted;
          bout_d  = fs_bout;
          // brw_q is the borrow into the MSB here.
          v_d     = brw_q ^ fs_bout;
          z_d     = ~|shifted;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      brw_q   <= 1'b0;
      d_q     <= '0;
      bout_q  <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      brw_q   <= brw_d;
      d_q     <= d_d;
      bout_q  <= bout_d;
      v_q     <= v_d;
      z_q     <= z_d;
    end
  end

  assign D    = d_q;
  assign Bout = bout_q;
  assign V    = v_q;
  assign Z    = z_q;
  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_four_bit_serial_subtractor.sv
// Self-checking bench for four_bit_serial_subtractor (WIDTH=4).
// Scoreboard of expected results, compared on each done pulse.
module tb_four_bit_serial_subtractor;

  localparam int W = 4;

  typedef struct {
    logic [W-1:0] d;
    logic         bo;
    logic         v;
    logic         z;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Bin;
  logic [W-1:0] D;
  logic         Bout;
  logic         V;
  logic         Z;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;
  int dones  = 0;
  exp_t q[$];
  exp_t last_exp;

  four_bit_serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .Bin   (Bin),
    .D     (D),
    .Bout  (Bout),
    .V     (V),
    .Z     (Z),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [15:0] got, logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(logic [W-1:0] a, logic [W-1:0] b,
                                 logic bin);
    exp_t e;
    int   r;
    int   sa;
    int   sb;
    int   s;
    r    = int'(a) - int'(b) - int'(bin);
    e.d  = W'(r);
    e.bo = (r < 0);
    sa   = a[W-1] ? int'(a) - (1 << W) : int'(a);
    sb   = b[W-1] ? int'(b) - (1 << W) : int'(b);
    s    = sa - sb - int'(bin);
    e.v  = (s > (1 << (W-1)) - 1) || (s < -(1 << (W-1)));
    e.z  = (e.d == '0);
    return e;
  endfunction

  // Scoreboard consumer: every done pulse must match the oldest entry.
  logic done_prev = 1'b0;
  always @(negedge clk) begin
    if (done) begin
      exp_t e;
      dones++;
      chk("done_prev_low", {15'd0, done_prev}, 16'd0);
      if (q.size() == 0) begin
        chk("unexpected_done", 16'd1, 16'd0);
      end else begin
        e = q.pop_front();
        chk("D", {12'd0, D}, {12'd0, e.d});
        chk("Bout", {15'd0, Bout}, {15'd0, e.bo});
        chk("V", {15'd0, V}, {15'd0, e.v});
        chk("Z", {15'd0, Z}, {15'd0, e.z});
      end
    end
    done_prev = done;
  end

  // One directed op; start is held through SHIFT/DONE with junk
  // operands to show it is ignored there.
  task automatic op(logic [W-1:0] a, logic [W-1:0] b, logic bin);
    exp_t e;
    @(negedge clk);
    A     = a;
    B     = b;
    Bin   = bin;
    start = 1'b1;
    e     = model(a, b, bin);
    q.push_back(e);
    @(posedge clk);
    #1;
    A   = ~a;
    B   = ~b;
    Bin = ~bin;
    chk("busy_shift", {15'd0, busy}, 16'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("done_early", {15'd0, done}, 16'd0);
    chk("D_held", {12'd0, D}, {12'd0, last_exp.d});
    @(posedge clk);
    #1;
    chk("done_latency", {15'd0, done}, 16'd1);
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("done_fall", {15'd0, done}, 16'd0);
    chk("busy_idle", {15'd0, busy}, 16'd0);
    last_exp = e;
  endtask

  initial begin
    exp_t e;
    int   d0;
    rst        = 1'b1;
    start      = 1'b0;
    A          = '0;
    B          = '0;
    Bin        = 1'b0;
    last_exp.d = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_D", {12'd0, D}, 16'd0);
    chk("rst_flags", {12'd0, Bout, V, Z, busy}, 16'd0);
    chk("rst_done", {15'd0, done}, 16'd0);
    @(negedge clk);
    rst = 1'b0;

    op(4'b0111, 4'b0011, 1'b0);
    op(4'b0011, 4'b0111, 1'b0);
    op(4'b0111, 4'b1000, 1'b0);
    op(4'b0101, 4'b0101, 1'b0);
    op(4'b0000, 4'b0000, 1'b1);
    op(4'b1000, 4'b0001, 1'b0);
    op(4'b1111, 4'b1110, 1'b1);

    // Back-to-back with start held high and operands changing.
    d0 = dones;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      start = 1'b1;
      A     = W'($urandom);
      B     = W'($urandom);
      Bin   = 1'($urandom);
      if (k % 6 == 0) begin
        e = model(A, B, Bin);
        q.push_back(e);
      end
    end
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("b2b_count", 16'(dones - d0), 16'd4);
    chk("b2b_q_empty", 16'(q.size()), 16'd0);

    // Reset between the 2nd and 3rd SHIFT edges.
    op(4'b1001, 4'b0010, 1'b0);
    @(negedge clk);
    A     = 4'b0001;
    B     = 4'b0110;
    Bin   = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    d0    = dones;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_mid_D", {12'd0, D}, 16'd0);
    chk("rst_mid_flags", {12'd0, Bout, V, Z, busy}, 16'd0);
    chk("rst_mid_done", {15'd0, done}, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("rst_no_done", 16'(dones - d0), 16'd0);
    last_exp.d = '0;
    op(4'b0110, 4'b0001, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("final_q_empty", 16'(q.size()), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/four_bit_serial_subtractor.md
FOUR_BIT_SERIAL_SUBTRACTOR -- requirements
Module: four_bit_serial_subtractor

Interface
REQ-001 Parameter WIDTH, default 4: operand and result width in bits; legal values 2..16.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 start  input  1  request to subtract; accepted only in IDLE.
REQ-005 A  input  WIDTH  minuend; sampled on the accepting edge only.
REQ-006 B  input  WIDTH  subtrahend; sampled on the accepting edge only.
REQ-007 Bin  input  1  borrow-in; sampled on the accepting edge only.
REQ-008 D  output  WIDTH  difference A - B - Bin, modulo 2^WIDTH.
REQ-009 Bout  output  1  borrow-out; 1 when unsigned A < B + Bin.
REQ-010 V  output  1  two's-complement overflow of the subtraction.
REQ-011 Z  output  1  1 when D is all zeros.
REQ-012 busy  output  1  1 in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse; D/Bout/V/Z are valid and newly updated.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-015 In IDLE with start=1 at a rising edge, the block SHALL latch A, B and Bin, clear the bit counter, and enter SHIFT.
REQ-016 In SHIFT, each edge SHALL process bit[cnt]: diff = a^b^brw; brw_next = (~a&b) | (~(a^b)&brw); diff goes into an internal result register, and cnt increments.
REQ-017 After the edge that processes bit WIDTH-1, the block SHALL enter DONE and write D, Bout, V and Z together on that same edge.
REQ-018 Latency: with start accepted at edge E0, done SHALL be high for exactly the cycle following edge E0+WIDTH, i.e. one cycle.
REQ-019 The block SHALL return from DONE to IDLE unconditionally on the next edge.
REQ-020 V SHALL equal (borrow into the MSB) XOR Bout.
REQ-021 D, Bout, V and Z SHALL hold their values from the DONE-entry edge until the next DONE entry; they SHALL NOT change during SHIFT.
REQ-022 start in SHIFT or DONE SHALL be ignored: no latch, no queueing, and no effect on the current operation.
REQ-023 Input changes on A, B or Bin after the accepting edge SHALL have no effect on the result.
REQ-024 Back-to-back operation: start asserted in the IDLE cycle right after DONE SHALL be accepted, so one operation completes every WIDTH+2 cycles.

Reset
REQ-025 While rst=1, the block SHALL force the state to IDLE, the counter to 0, and the internal borrow and result registers to 0, without waiting for a clock edge.
REQ-026 Reset values SHALL be D=0, Bout=0, V=0, Z=0, busy=0 and done=0.
REQ-027 rst asserted mid-SHIFT SHALL abandon the operation: no done pulse, and outputs take their reset values.
REQ-028 The first start can be accepted on the first rising edge after rst deasserts.

Structure
REQ-029 A shared package SHALL hold the state enum (IDLE, SHIFT, DONE) and the default WIDTH constant.
REQ-030 One sub-module, full_subtractor (inputs X, Y, Bin; outputs Diff, Bout), SHALL implement the per-bit cell and be instantiated exactly once.
REQ-031 The counter SHALL be $clog2(WIDTH) bits wide, and the design SHALL have no combinational path from inputs to outputs.

Verification (WIDTH=4)
REQ-032 A=0111, B=0011, Bin=0, start at E0 -> done high after E4; D=0100, Bout=0, V=0, Z=0.
REQ-033 A=0011, B=0111, Bin=0 -> D=1100, Bout=1, V=0, Z=0; A=0111, B=1000 -> D=1111, Bout=1, V=1.
REQ-034 A=0101, B=0101, Bin=0 -> D=0000, Z=1; A=0000, B=0000, Bin=1 -> D=1111, Bout=1, V=0.
REQ-035 start held high continuously with operands changing every cycle -> one accept every 6 cycles; each result matches the operands sampled at its accepting edge.
REQ-036 rst pulsed between the 2nd and 3rd SHIFT edges -> no done pulse, all outputs 0 immediately, and a fresh op completes normally afterwards.
